// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel front end: default pixel width and the
// 3x3 window element ordering (row-major, row 0 oldest, column 0 leftmost).
package sobel_pkg;

  localparam int DEFAULT_PIX_W = 8;

  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/sync_ram_block.sv
// Simple dual-port RAM: port a writes and reads, port b reads only.
// Read data is combinational from a registered read address.
module sync_ram_block #(
  parameter  int WIDTH_P = 16,
  parameter  int DEPTH_P = 640,
  localparam int ADDR_W  = $clog2(DEPTH_P)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               wr_en_a_i,
  input  logic [ADDR_W-1:0]  wr_addr_a_i,
  input  logic [WIDTH_P-1:0] wr_data_a_i,
  input  logic               rd_en_a_i,
  input  logic [ADDR_W-1:0]  rd_addr_a_i,
  output logic [WIDTH_P-1:0] data_a_o,
  input  logic               rd_en_b_i,
  input  logic [ADDR_W-1:0]  rd_addr_b_i,
  output logic [WIDTH_P-1:0] data_b_o
);

  logic [WIDTH_P-1:0] mem [DEPTH_P];
  logic [ADDR_W-1:0]  rd_addr_a_q;
  logic [ADDR_W-1:0]  rd_addr_b_q;

  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // address registers are reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_a_i) mem[wr_addr_a_i] <= wr_data_a_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
    end else begin
      if (rd_en_a_i) rd_addr_a_q <= rd_addr_a_i;
      if (rd_en_b_i) rd_addr_b_q <= rd_addr_b_i;
    end
  end

  assign data_a_o = mem[rd_addr_a_q];
  assign data_b_o = mem[rd_addr_b_q];

endmodule

// File: rtl/sobel_window_gen.sv
// Builds a 3x3 neighbourhood window for every interior pixel of a raster
// stream, using one line RAM that packs the two previous rows per column.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int PIX_W      = DEFAULT_PIX_W,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [PIX_W-1:0]   pixel_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [9*PIX_W-1:0] window_o,
  output logic               out_last_o
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0]      col_q, col_d, rd_addr;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [8:0][PIX_W-1:0] sh_q, sh_d;
  logic [8:0][PIX_W-1:0] win_q;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, last_d;
  logic                  acc, emit;
  logic [2*PIX_W-1:0]    ram_rd_data, ram_wr_data;
  logic [2*PIX_W-1:0]    ram_b_unused;
  logic [PIX_W-1:0]      above1, above2;

  assign in_ready_o  = !out_valid_q || out_ready_i;
  assign acc         = in_valid_i && in_ready_o;
  assign above1      = ram_rd_data[2*PIX_W-1:PIX_W];
  assign above2      = ram_rd_data[PIX_W-1:0];
  assign ram_wr_data = {pixel_i, above1};
  // Read address runs one column ahead so mem[x] is on data when pixel x arrives.
  assign rd_addr     = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
  assign emit        = acc && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
  assign last_d      = (row_q == ROW_LAST) && (col_q == COL_LAST);

  sync_ram_block #(
    .WIDTH_P (2 * PIX_W),
    .DEPTH_P (IMG_WIDTH)
  ) u_line_ram (
    .clk_i       (clk_i),
    .rstn_i      (~rst_i),
    .wr_en_a_i   (acc),
    .wr_addr_a_i (col_q),
    .wr_data_a_i (ram_wr_data),
    .rd_en_a_i   (acc),
    .rd_addr_a_i (rd_addr),
    .data_a_o    (ram_rd_data),
    .rd_en_b_i   (1'b0),
    .rd_addr_b_i ('0),
    .data_b_o    (ram_b_unused)
  );

  // NOTE: every variable gets its default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    sh_d        = sh_q;
    out_valid_d = out_valid_q;
    if (acc) begin
      col_d = rd_addr;
      if (col_q == COL_LAST) row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      sh_d[WIN_TL] = sh_q[WIN_TC];
      sh_d[WIN_TC] = sh_q[WIN_TR];
      sh_d[WIN_TR] = above2;
      sh_d[WIN_ML] = sh_q[WIN_MC];
      sh_d[WIN_MC] = sh_q[WIN_MR];
      sh_d[WIN_MR] = above1;
      sh_d[WIN_BL] = sh_q[WIN_BC];
      sh_d[WIN_BC] = sh_q[WIN_BR];
      sh_d[WIN_BR] = pixel_i;
    end
    if (emit)             out_valid_d = 1'b1;
    else if (out_ready_i) out_valid_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q       <= '0;
      row_q       <= '0;
      sh_q        <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      sh_q        <= sh_d;
      out_valid_q <= out_valid_d;
      if (emit) begin
        win_q      <= sh_d;
        out_last_q <= last_d;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign window_o    = win_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench: a 4x4 and a 5x4 instance driven with directed and
// randomized streams, compared against a window list built from the frame.
module tb_sobel_window_gen;

  typedef struct packed {
    logic        last;
    logic [71:0] win;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v4, ir4, ov4, or4, last4;
  logic [7:0]  p4;
  logic [71:0] w4;
  logic        v5, ir5, ov5, or5, last5;
  logic [7:0]  p5;
  logic [71:0] w5;

  int   n_cmp = 0;
  int   n_err = 0;
  obs_t cap4[$];
  obs_t cap5[$];
  obs_t exp_q[$];
  logic [7:0] frame_q[$];

  sobel_window_gen #(.PIX_W(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v4), .in_ready_o(ir4), .pixel_i(p4),
    .out_valid_o(ov4), .out_ready_i(or4), .window_o(w4), .out_last_o(last4)
  );

  sobel_window_gen #(.PIX_W(8), .IMG_WIDTH(5), .IMG_HEIGHT(4)) dut5 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(v5), .in_ready_o(ir5), .pixel_i(p5),
    .out_valid_o(ov5), .out_ready_i(or5), .window_o(w5), .out_last_o(last5)
  );

  // Inputs change 1 time unit after posedge, so at negedge a high valid/ready
  // pair means the transfer happens on the coming edge.
  always @(negedge clk) begin
    if (!rst && ov4 && or4) cap4.push_back({last4, w4});
    if (!rst && ov5 && or5) cap5.push_back({last5, w5});
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input bit sel, input logic [7:0] p, input bit rnd);
    bit ok;
    ok = 1'b0;
    if (sel) begin v5 = 1'b1; p5 = p; end
    else     begin v4 = 1'b1; p4 = p; end
    for (int n = 0; n < 64 && !ok; n++) begin
      if (rnd) or5 = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = sel ? ir5 : ir4;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout", 80'(ok), 80'd1);
    if (sel) v5 = 1'b0;
    else     v4 = 1'b0;
  endtask

  // Streams frame positions first..last (value = base + position) into dut4.
  task automatic stream4(input int first, input int last_i, input int base, input bit chk);
    for (int i = first; i <= last_i; i++) begin
      send(1'b0, 8'(base + i), 1'b0);
      if (chk)
        check($sformatf("valid_after_pos%0d", i), 80'(ov4), 80'((i % 4 >= 2) && (i / 4 >= 2)));
    end
  endtask

  // Every interior pixel (x,y) of a w x h frame yields the 3x3 block whose
  // bottom-right corner is (x,y); element (r,c) sits at byte 3r+c.
  task automatic model_frame(input int w, input int h, input int off);
    obs_t e;
    for (int y = 2; y < h; y++)
      for (int x = 2; x < w; x++) begin
        e = '0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            e.win[8*(3*r+c) +: 8] = frame_q[off + (y - 2 + r) * w + (x - 2 + c)];
        e.last = (y == h - 1) && (x == w - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic compare(input string tag, input bit sel);
    obs_t got[$];
    if (sel) got = cap5;
    else     got = cap4;
    check({tag, "_count"}, 80'(got.size()), 80'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_win%0d", tag, i), 80'(got[i]), 80'(exp_q[i]));
  endtask

  task automatic clear_all();
    cap4.delete();
    cap5.delete();
    exp_q.delete();
    frame_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    v4 = 1'b0; p4 = '0; or4 = 1'b1;
    v5 = 1'b0; p5 = '0; or5 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid",    80'(ov4),   80'd0);
    check("reset_last",     80'(last4), 80'd0);
    check("reset_window",   80'(w4),    80'd0);
    check("reset_in_ready", 80'(ir4),   80'd1);
    check("reset_valid5",   80'(ov5),   80'd0);
    rst = 1'b0;

    // Single 4x4 frame, downstream always ready.
    clear_all();
    for (int i = 0; i < 16; i++) frame_q.push_back(8'(i));
    model_frame(4, 4, 0);
    stream4(0, 15, 0, 1'b1);
    idle(3);
    compare("single", 1'b0);

    // Two back-to-back frames with different pixel values.
    clear_all();
    for (int i = 0; i < 16; i++) frame_q.push_back(8'(i));
    for (int i = 0; i < 16; i++) frame_q.push_back(8'(100 + i));
    model_frame(4, 4, 0);
    model_frame(4, 4, 16);
    stream4(0, 15, 0, 1'b1);
    stream4(0, 15, 100, 1'b1);
    idle(3);
    compare("b2b", 1'b0);

    // Downstream stall of 5 cycles on the first window.
    clear_all();
    for (int i = 0; i < 16; i++) frame_q.push_back(8'(i));
    model_frame(4, 4, 0);
    stream4(0, 10, 0, 1'b0);
    check("stall_pre_valid", 80'(ov4), 80'd1);
    or4 = 1'b0;
    v4  = 1'b1;
    p4  = 8'd11;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("stall_valid",    80'(ov4), 80'd1);
      check("stall_window",   80'(w4),  80'(exp_q[0].win));
      check("stall_in_ready", 80'(ir4), 80'd0);
    end
    or4 = 1'b1;
    stream4(11, 15, 0, 1'b0);
    idle(3);
    compare("stall", 1'b0);

    // 5x4: random input gaps and random downstream ready over three frames.
    clear_all();
    for (int i = 0; i < 20; i++) frame_q.push_back(8'(i));
    for (int i = 0; i < 40; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    model_frame(5, 4, 0);
    model_frame(5, 4, 20);
    model_frame(5, 4, 40);
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) begin
        or5 = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
      send(1'b1, frame_q[i], 1'b1);
    end
    or5 = 1'b1;
    idle(4);
    compare("random5x4", 1'b1);

    // Reset in the middle of a frame, then a clean frame.
    clear_all();
    for (int i = 0; i < 16; i++) frame_q.push_back(8'(i));
    model_frame(4, 4, 0);
    stream4(0, 6, 0, 1'b1);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("midreset_valid", 80'(ov4), 80'd0);
    end
    rst = 1'b0;
    cap4.delete();
    stream4(0, 15, 0, 1'b1);
    idle(3);
    compare("after_reset", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Upstream feeder of the Sobel kernel. Accepts a raster pixel stream and emits a 3x3 neighbourhood window for every interior pixel.
- Stores the two previous image rows in one sync_ram_block instance. Each RAM word packs two pixels per column, which keeps it single-write, single-read.
- Output is a registered valid/ready stream consumed by the gradient stage.

Parameters:
- PIX_W, 8, pixel width in bits.
- IMG_WIDTH, 640, pixels per row; must be >= 3.
- IMG_HEIGHT, 480, rows per frame; must be >= 3.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_valid_i  in  1  input pixel valid
- in_ready_o  out  1  input pixel accepted when in_valid_i and in_ready_o are both high
- pixel_i  in  PIX_W  raster-order pixel
- out_valid_o  out  1  window valid
- out_ready_i  in  1  downstream ready
- window_o  out  9*PIX_W  element (r,c) at bits [PIX_W*(3r+c) +: PIX_W]; r=0 is the oldest row, c=0 is the leftmost column
- out_last_o  out  1  high with the final window of a frame

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset values: out_valid_o=0, out_last_o=0, window_o=0, col=0, row=0, window shift registers=0.
  - RAM contents are not cleared. Stale data is never emitted because of the row>=2 gate.
- Handshake: in_ready_o = !out_valid_o || out_ready_i, combinational, single output slot. Only one port holds the state; no combinational path from in_valid_i to out_valid_o.
- Accept event is acc = in_valid_i && in_ready_o. Nothing below advances without acc.
- RAM word: 2*PIX_W bits, upper half = p(y-1,x), lower half = p(y-2,x). DEPTH_P = IMG_WIDTH. Port a is used; port b is tied off (rd_en_b_i=0).
- RAM timing:
  - RAM read data is combinational from a registered read address. The read address is kept one step ahead: rd_en_a_i=acc, rd_addr_a_i = next column (col+1, or 0 when col==IMG_WIDTH-1).
  - When the pixel for column x arrives, data_a_o already shows mem[x].
  - On acc, write mem[col] <= {pixel_i, upper(data_a_o)}.
  - The write address is never the address being read on the next cycle, since IMG_WIDTH >= 3.
- Column shift registers (3 per row): on acc, shift left.
  - New rightmost column is {lower(data_a_o), upper(data_a_o), pixel_i} for rows 0, 1, 2.
- Counters:
  - col increments on acc and wraps at IMG_WIDTH-1 -> 0, incrementing row.
  - row wraps at IMG_HEIGHT-1 -> 0, which starts a new frame.
  - Windows do not straddle rows: a window is emitted only when col>=2.
- Emit:
  - On acc with row>=2 and col>=2, the next edge loads window_o from the post-shift columns and sets out_valid_o=1.
  - out_last_o = (row==IMG_HEIGHT-1 && col==IMG_WIDTH-1).
  - Latency is 1 cycle from the accepting edge.
- Out-stall and clear rules:
  - Output holds while out_valid_o && !out_ready_i; in_ready_o=0 during the stall.
  - out_valid_o clears when out_ready_i is high and there is no new emit in the same cycle.
  - A simultaneous drain and emit keeps out_valid_o=1 with the new window.
- Output count per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). Border pixels produce no window.
- Reset mid-frame: the next accepted pixel is treated as (0,0); any pending window is dropped.

Decomposition:
- sobel_pkg holds:
  - PIX_W default.
  - Window index localparams (WIN_TL..WIN_BR = 0..8).
  - A function win_idx(r,c) returning 3r+c.
- Sub-module: one sync_ram_block instance (WIDTH_P=2*PIX_W, DEPTH_P=IMG_WIDTH, rstn_i = ~rst_i).
- Counters, shift registers and the output slot live in the top module.

Test Plan:
- IMG 4x4, PIX_W=8, pixels 0..15 streamed, out_ready_i=1:
  - First out_valid_o appears 1 cycle after pixel 10 is accepted, with rows {0,1,2},{4,5,6},{8,9,10}.
  - Exactly 4 windows are produced.
- Same stream, last window:
  - Rows {5,6,7},{9,10,11},{13,14,15} with out_last_o=1.
  - No window is emitted after pixels 12 or 13.
- Two back-to-back 4x4 frames (0..15 then 100..115):
  - Frame 2's first window is {100,101,102},{104,105,106},{108,109,110}, not mixed with frame 1.
- out_ready_i=0 for 5 cycles while a window is pending:
  - window_o and out_valid_o stay stable and in_ready_o=0.
  - After release, the window sequence is unchanged.
- Random in_valid_i gaps plus random out_ready_i on 5x4 pixels 0..19:
  - 6 windows, bit-exact against the reference model.
- rst_i asserted after pixel 6, then pixels 0..15 re-sent:
  - out_valid_o=0 while reset is high.
  - Output is identical to the first scenario.
